// File: rtl/prbs_checker.sv
// Self-synchronising checker for the period-3 pattern b[n] = b[n-1] ^ b[n-2].
// Locks after LOCK_COUNT clean bits, counts errors while locked, and unlocks on an error burst.
module prbs_checker #(
  parameter int LOCK_COUNT  = 8,
  parameter int UNLOCK_ERRS = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear_errs,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam int MS_W = $clog2(UNLOCK_ERRS + 1);
  localparam logic [MC_W-1:0] LOCK_LAST   = MC_W'(LOCK_COUNT - 1);
  localparam logic [MS_W-1:0] UNLOCK_LAST = MS_W'(UNLOCK_ERRS - 1);

  typedef enum logic [1:0] {FILL, SEARCH, LOCKED} state_e;

  state_e           state_q;
  logic [1:0]       hist_q;
  logic             fill_q;
  logic [MC_W-1:0]  match_cnt_q;
  logic [MS_W-1:0]  miss_cnt_q;
  logic             locked_q;
  logic             err_pulse_q;
  logic [ERR_W-1:0] err_count_q;

  logic predict_d;
  logic match_d;

  // An all-zero window never matches, so a stuck-at-0 line cannot lock.
  assign predict_d = hist_q[0] ^ hist_q[1];
  assign match_d   = (in_bit == predict_d) && !(hist_q == 2'b00 && !in_bit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      hist_q      <= 2'b00;
      fill_q      <= 1'b0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (in_valid) begin
        hist_q <= {hist_q[0], in_bit};
        unique case (state_q)
          FILL: begin
            fill_q <= 1'b1;
            if (fill_q) state_q <= SEARCH;
          end
          SEARCH: begin
            if (!match_d) begin
              match_cnt_q <= '0;
            end else if (match_cnt_q == LOCK_LAST) begin
              state_q    <= LOCKED;
              locked_q   <= 1'b1;
              miss_cnt_q <= '0;
            end else begin
              match_cnt_q <= match_cnt_q + MC_W'(1);
            end
          end
          LOCKED: begin
            if (match_d) begin
              miss_cnt_q <= '0;
            end else begin
              err_pulse_q <= 1'b1;
              if (err_count_q != {ERR_W{1'b1}}) err_count_q <= err_count_q + ERR_W'(1);
              if (miss_cnt_q == UNLOCK_LAST) begin
                state_q     <= SEARCH;
                locked_q    <= 1'b0;
                match_cnt_q <= '0;
                miss_cnt_q  <= '0;
              end else begin
                miss_cnt_q <= miss_cnt_q + MS_W'(1);
              end
            end
          end
          default: state_q <= FILL;
        endcase
      end
      // Clear wins over a same-cycle increment; err_pulse is unaffected.
      if (clear_errs) err_count_q <= '0;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule
